// File: rtl/conv1d_engine.sv
// 1-D convolution engine: streams samples out of a shared SRAM through a K-tap MAC
// and writes saturated, optionally ReLU-clamped, results back into the same SRAM.
module conv1d_engine #(
    parameter  int NUM_WORDS  = 128,
    parameter  int DATA_WIDTH = 32,
    parameter  int SAMPLE_W   = 16,
    parameter  int MAX_K      = 16,
    localparam int AW         = $clog2(NUM_WORDS),
    localparam int KW         = $clog2(MAX_K + 1),
    localparam int TW         = $clog2(MAX_K)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cfg_start_i,
    input  logic [AW-1:0]           cfg_in_addr_i,
    input  logic [AW-1:0]           cfg_out_addr_i,
    input  logic [AW:0]             cfg_len_i,
    input  logic [KW-1:0]           cfg_ksize_i,
    input  logic [3:0]              cfg_stride_i,
    input  logic                    cfg_pad_i,
    input  logic                    cfg_relu_i,
    input  logic                    krn_we_i,
    input  logic [TW-1:0]           krn_idx_i,
    input  logic [SAMPLE_W-1:0]     krn_data_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    ext_gnt_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [AW-1:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
    localparam int ACCW = 2 * SAMPLE_W + KW;
    localparam int OSW  = AW + 5;
    localparam int NW   = AW + 1;
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'($signed({1'b0, {(DATA_WIDTH-1){1'b1}}}));
    localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'($signed({1'b1, {(DATA_WIDTH-1){1'b0}}}));

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t                     state;
    logic [AW-1:0]              in_addr, out_addr;
    logic [AW:0]                len, nout, out_idx;
    logic [KW-1:0]              ksize, tap_k;
    logic [3:0]                 stride;
    logic                       pad, relu;
    logic [OSW-1:0]             os;
    logic signed [SAMPLE_W-1:0] taps [MAX_K];
    logic signed [SAMPLE_W-1:0] mac_tap;
    logic                       mac_vld;
    logic signed [ACCW-1:0]     acc;

    logic [31:0]                len32, k32, s32, nout32;
    logic                       cfg_err;
    logic [KW-1:0]              pad_amt;
    int                         idx;
    logic                       in_range;
    logic [AW-1:0]              rd_addr;
    logic [DATA_WIDTH-1:0]      wr_data;
    logic signed [SAMPLE_W-1:0]   sample;
    logic signed [2*SAMPLE_W-1:0] prod;
    logic                       unused_rdata;

    assign unused_rdata = ^mem_rdata_i[DATA_WIDTH-1:SAMPLE_W];
    assign sample       = mem_rdata_i[SAMPLE_W-1:0];
    assign prod         = (2*SAMPLE_W)'(sample) * (2*SAMPLE_W)'(mac_tap);
    assign ext_gnt_o    = !busy_o;

    // Output count and bounds check, evaluated on the latched configuration.
    always_comb begin
        len32 = 32'(len);
        k32   = 32'(ksize);
        s32   = (stride == 4'd0) ? 32'd1 : 32'(stride);
        if (pad)
            nout32 = (len32 - 32'd1) / s32 + 32'd1;
        else if (k32 > len32)
            nout32 = 32'd0;
        else
            nout32 = (len32 - k32) / s32 + 32'd1;
        cfg_err = (ksize == '0) || (k32 > 32'(MAX_K)) || (stride == 4'd0) || (len == '0) ||
                  (!pad && (len32 < k32)) ||
                  (32'(in_addr) + len32 > 32'(NUM_WORDS)) ||
                  (32'(out_addr) + nout32 > 32'(NUM_WORDS));
    end

    // Sample index for the current tap; padded positions fall outside [0, len).
    always_comb begin
        pad_amt  = pad ? ((ksize - KW'(1)) >> 1) : '0;
        idx      = int'(os) + int'(tap_k) - int'(pad_amt);
        in_range = (idx >= 0) && (idx < int'(len));
        rd_addr  = in_addr + idx[AW-1:0];
    end

    always_comb begin
        if (relu && acc[ACCW-1])
            wr_data = '0;
        else if (acc > SAT_MAX)
            wr_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (acc < SAT_MIN)
            wr_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            wr_data = acc[DATA_WIDTH-1:0];
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (state == S_READ && in_range) begin
            mem_req_o  = 1'b1;
            mem_addr_o = rd_addr;
        end else if (state == S_WRITE) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_be_o    = '1;
            mem_addr_o  = out_addr + out_idx[AW-1:0];
            mem_wdata_o = wr_data;
        end
    end

    // NOTE: state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            in_addr  <= '0;
            out_addr <= '0;
            len      <= '0;
            ksize    <= '0;
            stride   <= '0;
            pad      <= 1'b0;
            relu     <= 1'b0;
            nout     <= '0;
            out_idx  <= '0;
            os       <= '0;
            tap_k    <= '0;
            mac_tap  <= '0;
            mac_vld  <= 1'b0;
            acc      <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            // NOTE: the tap file is a small flop array rather than a RAM macro, so clearing it in reset is legal.
            for (int t = 0; t < MAX_K; t++) taps[t] <= '0;
        end else begin
            done_o  <= 1'b0;
            mac_vld <= (state == S_READ) && in_range;
            mac_tap <= taps[tap_k[TW-1:0]];
            if (mac_vld) acc <= acc + ACCW'(prod);
            if (krn_we_i && (state == S_IDLE || state == S_DONE))
                taps[krn_idx_i] <= krn_data_i;

            case (state)
                S_IDLE: if (cfg_start_i) begin
                    in_addr  <= cfg_in_addr_i;
                    out_addr <= cfg_out_addr_i;
                    len      <= cfg_len_i;
                    ksize    <= cfg_ksize_i;
                    stride   <= cfg_stride_i;
                    pad      <= cfg_pad_i;
                    relu     <= cfg_relu_i;
                    err_o    <= 1'b0;
                    busy_o   <= 1'b1;
                    state    <= S_CHECK;
                end
                S_CHECK: begin
                    nout    <= nout32[AW:0];
                    out_idx <= '0;
                    os      <= '0;
                    tap_k   <= '0;
                    acc     <= '0;
                    if (cfg_err) begin
                        err_o  <= 1'b1;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    if (tap_k == ksize - KW'(1)) state <= S_DRAIN;
                    else                         tap_k <= tap_k + KW'(1);
                end
                S_DRAIN: state <= S_WRITE;
                S_WRITE: begin
                    acc   <= '0;
                    tap_k <= '0;
                    if (out_idx + NW'(1) < nout) begin
                        out_idx <= out_idx + NW'(1);
                        os      <= os + OSW'(stride);
                        state   <= S_READ;
                    end else begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/conv1d_engine.md
CONV1D_ENGINE -- requirements
Module: conv1d_engine

Interface
REQ-001 Parameter NUM_WORDS, default 128, internal SRAM depth in words; AW = clog2(NUM_WORDS).
REQ-002 Parameter DATA_WIDTH, default 32, SRAM word and output width.
REQ-003 Parameter SAMPLE_W, default 16, signed sample/tap width; samples occupy word bits [SAMPLE_W-1:0].
REQ-004 Parameter MAX_K, default 16, maximum kernel taps; KW = clog2(MAX_K+1).
REQ-005 Ports, in order (name  direction  width  meaning):
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- cfg_start_i  in  1  start pulse, accepted only in IDLE
- cfg_in_addr_i  in  AW  first input-sample word
- cfg_out_addr_i  in  AW  first output word
- cfg_len_i  in  AW+1  input length L
- cfg_ksize_i  in  KW  kernel size K
- cfg_stride_i  in  4  stride S
- cfg_pad_i  in  1  0 = valid (P=0), 1 = same (P=(K-1)/2, zero padding)
- cfg_relu_i  in  1  clamp negative outputs to 0
- krn_we_i / krn_idx_i / krn_data_i  in  1 / clog2(MAX_K) / SAMPLE_W  tap register write
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  config error, sticky until next accepted start
- ext_gnt_o  out  1  high = external (bus) requester owns SRAM
- mem_req_o / mem_we_o  out  1 / 1  SRAM request / write enable
- mem_be_o  out  DATA_WIDTH/8  byte enables
- mem_addr_o  out  AW  SRAM address
- mem_wdata_o  out  DATA_WIDTH  write data
- mem_rdata_i  in  DATA_WIDTH  read data, valid the cycle after a read request

Function
REQ-006 FSM states: IDLE, CHECK, READ, DRAIN, WRITE, DONE; configuration is latched on the accepted start.
REQ-007 IDLE -> CHECK on cfg_start_i; cfg_start_i is ignored in every other state.
REQ-008 CHECK flags an error if K=0, K>MAX_K, S=0, L=0, valid mode with L<K, in_addr+L>NUM_WORDS, or out_addr+Nout>NUM_WORDS; on error -> DONE with no SRAM access, else -> READ.
REQ-009 Nout = floor((L-K)/S)+1 in valid mode, floor((L-1)/S)+1 in same mode.
REQ-010 For output o, READ spends exactly K cycles, tap k in cycle k, with sample index i = o*S + k - P.
REQ-011 If 0<=i<L the engine issues a read at in_addr+i; otherwise it issues no request and that tap contributes 0.
REQ-012 Read data is multiplied by tap k one cycle after the request; DRAIN (1 cycle) completes the last MAC.
REQ-013 Accumulator is signed, 2*SAMPLE_W+KW bits, cleared at the start of each output.
REQ-014 WRITE (1 cycle) writes the accumulator saturated to signed DATA_WIDTH to out_addr+o, with mem_be_o all ones; if cfg_relu, negative results are written as 0.
REQ-015 After WRITE: -> READ for output o+1 if o+1<Nout, else -> DONE.
REQ-016 DONE lasts 1 cycle with done_o=1, then -> IDLE.
REQ-017 busy_o=1 in CHECK, READ, DRAIN and WRITE; ext_gnt_o = !busy_o; mem_req_o=0 whenever ext_gnt_o=1.
REQ-018 Latency: with start high at cycle 0, done_o is high at cycle 2+Nout*(K+2).
REQ-019 krn_we_i writes tap krn_idx_i in IDLE or DONE only; writes while busy are ignored.
REQ-020 err_o is set entering DONE from CHECK and cleared on the next accepted start.

Reset
REQ-021 While rst_i=1 at a clock edge: state=IDLE, all taps=0, accumulator=0, busy_o=0, done_o=0, err_o=0, mem_req_o=0, mem_we_o=0, ext_gnt_o=1.
REQ-022 Reset mid-operation aborts immediately with no further SRAM access; already-written outputs are not restored.

Verification
REQ-023 Valid mode: L=5, x=[1,2,3,4,5], K=3, taps=[1,0,-1], S=1 -> words out..out+2 = -2,-2,-2; done_o at cycle 17.
REQ-024 Same mode: same data, S=1 -> 5 outputs -2,-2,-2,-2,4; S=2 -> 3 outputs -2,-2,4; no request is issued for padded taps.
REQ-025 Saturation/ReLU: K=2, x=[-32768,-32768], taps=[-32768,-32768] -> 0x7FFFFFFF; taps=[1,-2], x=[1,1], relu=1 -> 0.
REQ-026 Errors: K=0, S=0, or out_addr=126 with Nout=3 -> err_o=1, done_o at cycle 2, mem_req_o never asserted.
REQ-027 Arbitration/ignore: ext_gnt_o=0 exactly while busy_o=1; a second start and krn_we_i while busy have no effect; rst_i mid-READ -> IDLE the next cycle with ext_gnt_o=1 and taps=0.
